i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target at 7-bit address DEV_ADDR: written bytes appear on rx_data, read bytes come from tx_data.
// Optional 3-sample majority glitch filter on SCL/SDA, enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t     state, state_d;
    logic [1:0] scl_sync, sda_sync;
    logic       scl, sda, scl_q, sda_q;
    logic       scl_rise, scl_fall, start, stop, last_bit, load_tx;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [6:0] shift, shift_d, tx_shift, tx_shift_d;
    logic [7:0] rx_data_d;
    logic       rw, rw_d, sda_oe_d, busy_d, rx_valid_d, tx_req_d;

    // NOTE: sequential state is always written with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    assign scl = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
    assign sda = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;
    assign last_bit = (bit_cnt == 3'd7);
    // sda_oe doubles as the ACK phase flag: low before the ACK slot opens, high while it is driven.
    assign load_tx  = scl_fall && ((state == ADDR_ACK && sda_oe && rw) || state == READ_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            tx_shift <= 7'd0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            tx_shift <= tx_shift_d;
            rw       <= rw_d;
            sda_oe   <= sda_oe_d;
            busy     <= busy_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
            tx_req   <= tx_req_d;
        end
    end

    always_comb begin
        state_d = state;
        if (start) begin
            state_d = ADDR;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                ADDR:      if (scl_rise && last_bit) state_d = (shift == DEV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && sda_oe) state_d = rw ? READ : WRITE;
                WRITE:     if (scl_rise && last_bit) state_d = WRITE_ACK;
                WRITE_ACK: if (scl_fall && sda_oe) state_d = WRITE;
                READ:      if (scl_fall && bit_cnt == 3'd0) state_d = READ_ACK;
                READ_ACK: begin
                    if (scl_rise && sda) state_d = IGNORE;
                    else if (scl_fall)   state_d = READ;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        tx_shift_d = tx_shift;
        rw_d       = rw;
        sda_oe_d   = sda_oe;
        busy_d     = busy;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start) begin
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (load_tx) begin
            tx_shift_d = tx_data[6:0];
            sda_oe_d   = ~tx_data[7];
            bit_cnt_d  = 3'd0;
            tx_req_d   = 1'b1;
        end else begin
            case (state)
                ADDR, WRITE: if (scl_rise) begin
                    shift_d   = {shift[5:0], sda};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (last_bit && state == ADDR) begin
                        rw_d   = sda;
                        busy_d = (shift == DEV_ADDR);
                    end
                    if (last_bit && state == WRITE) begin
                        rx_data_d  = {shift, sda};
                        rx_valid_d = 1'b1;
                    end
                end
                ADDR_ACK, WRITE_ACK: if (scl_fall) sda_oe_d = ~sda_oe;
                READ: begin
                    if (scl_rise) bit_cnt_d = bit_cnt + 3'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d   = ~tx_shift[6];
                            tx_shift_d = {tx_shift[5:0], 1'b0};
                        end
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end
endmodule
